dice_roll_arbiter: RTL and testbench

Round-robin controller that shares one electronic-dice `roll` unit between `NUM_PLAYERS` requesters. It grants one player at a time and drives the dice `button` for a fixed roll window. It then lets the throw settle, samples it, checks that it is legal (1..6), retries on an illegal face, and returns the result to the granted player with a one-cycle `ack`. It sits between the player inputs and the single `roll` instance.

---
 rtl/dice_pkg.sv | 29 ++
 rtl/rr_picker.sv | 29 ++
 rtl/dice_roll_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dice_roll_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared state encoding, throw limits and score helpers for dice_roll_arbiter.
package dice_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRoll,
    StSettle,
    StCapture,
    StDone
  } state_e;

  localparam logic [2:0] THROW_MIN = 3'd1;
  localparam logic [2:0] THROW_MAX = 3'd6;
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned SCORE_W = 8;

  function automatic logic is_legal_throw(input logic [2:0] t);
    return (t >= THROW_MIN) && (t <= THROW_MAX);
  endfunction

  // Saturating accumulate of one throw into a player total.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [2:0]         b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {{(SCORE_W-2){1'b0}}, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request at or above ptr, with wrap.
module rr_picker #(
  parameter int unsigned NUM_PLAYERS = 4
) (
  input  logic [NUM_PLAYERS-1:0]         req,
  input  logic [$clog2(NUM_PLAYERS)-1:0] ptr,
  output logic [$clog2(NUM_PLAYERS)-1:0] idx,
  output logic                           found
);

  localparam int unsigned IdW = $clog2(NUM_PLAYERS);

  int unsigned cand;

  // Walk from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      cand = (32'(ptr) + NUM_PLAYERS - 1 - k) % NUM_PLAYERS;
      if (req[cand[IdW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/dice_roll_arbiter.sv
// Round-robin sharing of one dice roll unit; optional per-player score totals
// are built when ROLL_SCORE_EN is defined.
module dice_roll_arbiter
  import dice_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned ROLL_CYCLES = 13
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PLAYERS-1:0]         req,
  output logic [NUM_PLAYERS-1:0]         ack,
  output logic [2:0]                     result,
  output logic [$clog2(NUM_PLAYERS)-1:0] grant_id,
  output logic                           busy,
  output logic                           fault,
  output logic                           dice_button,
  input  logic [2:0]                     dice_throw
`ifdef ROLL_SCORE_EN
  ,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score
`endif
);

  localparam int unsigned IdW    = $clog2(NUM_PLAYERS);
  localparam int unsigned CntW   = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
  localparam logic [CntW-1:0]   RollLast  = CntW'(ROLL_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryLast = RetryW'(MAX_RETRY);

  state_e                  state_q, state_d;
  logic [IdW-1:0]          grant_q, grant_d;
  logic [IdW-1:0]          ptr_q, ptr_d;
  logic [CntW-1:0]         roll_cnt_q, roll_cnt_d;
  logic [RetryW-1:0]       retry_q, retry_d;
  logic [2:0]              result_q, result_d;
  logic                    fault_q, fault_d;
  logic [NUM_PLAYERS-1:0]  ack_q, ack_d;
  logic                    busy_q;
  logic [IdW-1:0]          pick_idx;
  logic                    pick_found;
  logic [CntW-1:0]         roll_last;

  rr_picker #(
    .NUM_PLAYERS(NUM_PLAYERS)
  ) u_rr_picker (
    .req  (req),
    .ptr  (ptr_q),
    .idx  (pick_idx),
    .found(pick_found)
  );

  // A retry re-presses the button for a single cycle only.
  assign roll_last = (retry_q != '0) ? '0 : RollLast;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    roll_cnt_d = roll_cnt_q;
    retry_d    = retry_q;
    result_d   = result_q;
    fault_d    = fault_q;
    ack_d      = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          roll_cnt_d = '0;
          state_d    = StRoll;
        end
      end
      StRoll: begin
        if (!req[grant_q]) begin
          retry_d = '0;
          state_d = StIdle;
        end else if (roll_cnt_q == roll_last) begin
          state_d = StSettle;
        end else begin
          roll_cnt_d = roll_cnt_q + 1'b1;
        end
      end
      StSettle: begin
        state_d = StCapture;
      end
      StCapture: begin
        if (is_legal_throw(dice_throw)) begin
          result_d       = dice_throw;
          ack_d[grant_q] = 1'b1;
          state_d        = StDone;
        end else if (retry_q == RetryLast) begin
          result_d       = THROW_MIN;
          fault_d        = 1'b1;
          ack_d[grant_q] = 1'b1;
          state_d        = StDone;
        end else begin
          retry_d    = retry_q + 1'b1;
          roll_cnt_d = '0;
          state_d    = StRoll;
        end
      end
      StDone: begin
        if (32'(grant_q) == NUM_PLAYERS - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = grant_q + 1'b1;
        end
        retry_d = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      ptr_q      <= '0;
      roll_cnt_q <= '0;
      retry_q    <= '0;
      result_q   <= '0;
      fault_q    <= 1'b0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      roll_cnt_q <= roll_cnt_d;
      retry_q    <= retry_d;
      result_q   <= result_d;
      fault_q    <= fault_d;
      ack_q      <= ack_d;
      busy_q     <= (state_d != StIdle);
    end
  end

  assign ack         = ack_q;
  assign result      = result_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign dice_button = (state_q == StRoll);

`ifdef ROLL_SCORE_EN
  logic [NUM_PLAYERS*SCORE_W-1:0] score_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q <= '0;
    end else if (state_q == StDone) begin
      score_q[grant_q*SCORE_W +: SCORE_W] <=
        sat_add(score_q[grant_q*SCORE_W +: SCORE_W], result_q);
    end
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_dice_roll_arbiter.sv
// Self-checking bench for dice_roll_arbiter (4 players, 4-cycle roll window).
module tb_dice_roll_arbiter;

  localparam int NP = 4;
  localparam int RC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] req = '0;
  logic [NP-1:0] ack;
  logic [2:0]    result;
  logic [1:0]    grant_id;
  logic          busy;
  logic          fault;
  logic          dice_button;
  logic [2:0]    dice_throw = 3'd1;
`ifdef ROLL_SCORE_EN
  logic [NP*8-1:0] score;
`endif

  int checks = 0;
  int fails  = 0;

  // Dice model: a new face appears each time the button is released.
  int faces[$];
  int default_face = 1;
  int ptr_m = 0;
  logic fault_m = 1'b0;

  int         o_ack_cyc, o_first, o_btn, o_pulses;
  logic [3:0] o_ack;
  logic [2:0] o_res;
  logic       o_fault;
  logic [1:0] o_gid;

  dice_roll_arbiter #(
    .NUM_PLAYERS(NP),
    .ROLL_CYCLES(RC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ack        (ack),
    .result     (result),
    .grant_id   (grant_id),
    .busy       (busy),
    .fault      (fault),
    .dice_button(dice_button),
    .dice_throw (dice_throw)
`ifdef ROLL_SCORE_EN
    ,
    .score      (score)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge dice_button) begin
    if (faces.size() > 0) dice_throw = 3'(faces.pop_front());
    else dice_throw = 3'(default_face);
  end

  function automatic int model_pick(input int ptr, input logic [3:0] mask);
    for (int k = 0; k < NP; k++) begin
      if (mask[(ptr + k) % NP]) return (ptr + k) % NP;
    end
    return -1;
  endfunction

  // Watch up to budget cycles (sampled on negedge) until an ack appears.
  task automatic observe(input int budget);
    logic prev;
    prev = dice_button;
    o_ack_cyc = -1; o_first = -1; o_btn = 0; o_pulses = 0;
    o_ack = '0; o_res = '0; o_fault = 1'b0; o_gid = '0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (dice_button) begin
        o_btn++;
        if (o_first < 0) o_first = n;
        if (!prev) o_pulses++;
      end
      prev = dice_button;
      if (ack !== 4'b0) begin
        o_ack_cyc = n; o_ack = ack; o_res = result; o_fault = fault; o_gid = grant_id;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    ptr_m = 0;
    fault_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    req = 4'($urandom_range(1, 15));
    repeat (3) @(negedge clk);
    checks++; if (ack !== 4'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", ack); end
    checks++; if (result !== 3'b0) begin fails++; $display("FAIL reset_result: got %0d want 0", result); end
    checks++; if (grant_id !== 2'b0) begin fails++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b want 0", fault); end
    checks++; if (dice_button !== 1'b0) begin fails++; $display("FAIL reset_button: got %b want 0", dice_button); end
`ifdef ROLL_SCORE_EN
    checks++; if (score !== 32'b0) begin fails++; $display("FAIL reset_score: got %h want 0", score); end
`endif
    req = '0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
    checks++; if (dice_button !== 1'b0) begin fails++; $display("FAIL idle_button: got %b want 0", dice_button); end
    ptr_m = 0;
    fault_m = 1'b0;
  endtask

  task automatic test_single();
    faces.delete(); faces.push_back(5);
    req = 4'b0100;
    observe(60);
    req = '0;
    checks++; if (o_ack_cyc != RC + 3) begin fails++; $display("FAIL single_latency: got %0d want %0d", o_ack_cyc, RC + 3); end
    checks++; if (o_btn != RC) begin fails++; $display("FAIL single_button_cycles: got %0d want %0d", o_btn, RC); end
    checks++; if (o_pulses != 1) begin fails++; $display("FAIL single_pulses: got %0d want 1", o_pulses); end
    checks++; if (o_ack !== 4'b0100) begin fails++; $display("FAIL single_ack: got %b want 0100", o_ack); end
    checks++; if (o_res !== 3'd5) begin fails++; $display("FAIL single_result: got %0d want 5", o_res); end
    checks++; if (o_gid !== 2'd2) begin fails++; $display("FAIL single_grant: got %0d want 2", o_gid); end
    ptr_m = 3;
  endtask

  task automatic test_rr();
    int order_a[4] = '{0, 1, 2, 3};
    int order_b[2] = '{0, 3};
    int fv;
    pulse_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      fv = $urandom_range(1, 6);
      faces.delete(); faces.push_back(fv);
      observe(60);
      checks++; if (o_ack !== 4'(1 << order_a[i])) begin fails++; $display("FAIL rr_order_a%0d: got %b want %b", i, o_ack, 4'(1 << order_a[i])); end
      checks++; if (o_res !== 3'(fv)) begin fails++; $display("FAIL rr_result_a%0d: got %0d want %0d", i, o_res, fv); end
      checks++; if (o_first != (i == 0 ? 1 : 2)) begin fails++; $display("FAIL rr_roll_start_a%0d: got %0d want %0d", i, o_first, (i == 0 ? 1 : 2)); end
      checks++; if (o_ack_cyc != (i == 0 ? RC + 3 : RC + 4)) begin fails++; $display("FAIL rr_latency_a%0d: got %0d want %0d", i, o_ack_cyc, (i == 0 ? RC + 3 : RC + 4)); end
      req = (o_ack == 4'b0) ? 4'b0 : (req & ~o_ack);
    end
    req = '0;
    @(negedge clk);
    req = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      fv = $urandom_range(1, 6);
      faces.delete(); faces.push_back(fv);
      observe(60);
      checks++; if (o_ack !== 4'(1 << order_b[i])) begin fails++; $display("FAIL rr_order_b%0d: got %b want %b", i, o_ack, 4'(1 << order_b[i])); end
      checks++; if (o_res !== 3'(fv)) begin fails++; $display("FAIL rr_result_b%0d: got %0d want %0d", i, o_res, fv); end
      req = (o_ack == 4'b0) ? 4'b0 : (req & ~o_ack);
    end
    req = '0;
    ptr_m = 0;
  endtask

  task automatic test_withdraw();
    default_face = 4;
    faces.delete();
    @(negedge clk);
    req = 4'b0001;
    observe(60);
    req = '0;
    checks++; if (o_ack !== 4'b0001) begin fails++; $display("FAIL wd_setup_ack: got %b want 0001", o_ack); end
    ptr_m = 1;
    @(negedge clk);
    req = 4'b0010;
    repeat (2) @(negedge clk);
    checks++; if (dice_button !== 1'b1) begin fails++; $display("FAIL wd_button_cycle2: got %b want 1", dice_button); end
    req = '0;
    @(negedge clk);
    checks++; if (dice_button !== 1'b0) begin fails++; $display("FAIL wd_button_after: got %b want 0", dice_button); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL wd_busy_after: got %b want 0", busy); end
    observe(12);
    checks++; if (o_ack_cyc != -1) begin fails++; $display("FAIL wd_no_ack: got ack %b at %0d want none", o_ack, o_ack_cyc); end
    req = 4'b1111;
    observe(60);
    req = '0;
    checks++; if (o_ack !== 4'(1 << model_pick(ptr_m, 4'b1111))) begin fails++; $display("FAIL wd_regrant: got %b want %b", o_ack, 4'(1 << model_pick(ptr_m, 4'b1111))); end
    ptr_m = 2;
    repeat (8) @(negedge clk);
    // Reset in the middle of a roll.
    req = 4'b0100;
    repeat (2) @(negedge clk);
    checks++; if (dice_button !== 1'b1) begin fails++; $display("FAIL rst_mid_setup: got %b want 1", dice_button); end
    rst = 1'b0;
    #1;
    checks++; if (dice_button !== 1'b0) begin fails++; $display("FAIL rst_mid_button: got %b want 0", dice_button); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rst_mid_grant: got %0d want 0", grant_id); end
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    ptr_m = 0;
    fault_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int p;
    p = $urandom_range(0, 3);
    faces.delete(); faces.push_back(7); faces.push_back(3);
    req = 4'(1 << p);
    observe(80);
    req = '0;
    checks++; if (o_ack_cyc != 10) begin fails++; $display("FAIL ill_latency: got %0d want 10", o_ack_cyc); end
    checks++; if (o_pulses != 2) begin fails++; $display("FAIL ill_pulses: got %0d want 2", o_pulses); end
    checks++; if (o_btn != RC + 1) begin fails++; $display("FAIL ill_button_cycles: got %0d want %0d", o_btn, RC + 1); end
    checks++; if (o_res !== 3'd3) begin fails++; $display("FAIL ill_result: got %0d want 3", o_res); end
    checks++; if (o_fault !== 1'b0) begin fails++; $display("FAIL ill_fault_clear: got %b want 0", o_fault); end
    ptr_m = (p + 1) % NP;
    @(negedge clk);
    faces.delete();
    default_face = 0;
    p = $urandom_range(0, 3);
    req = 4'(1 << p);
    observe(80);
    req = '0;
    fault_m = 1'b1;
    checks++; if (o_ack !== 4'(1 << p)) begin fails++; $display("FAIL exh_ack: got %b want %b", o_ack, 4'(1 << p)); end
    checks++; if (o_ack_cyc != RC + 3 + 3 * 3) begin fails++; $display("FAIL exh_latency: got %0d want %0d", o_ack_cyc, RC + 12); end
    checks++; if (o_pulses != 4) begin fails++; $display("FAIL exh_pulses: got %0d want 4", o_pulses); end
    checks++; if (o_res !== 3'd1) begin fails++; $display("FAIL exh_result: got %0d want 1", o_res); end
    checks++; if (o_fault !== 1'b1) begin fails++; $display("FAIL exh_fault: got %b want 1", o_fault); end
    ptr_m = (p + 1) % NP;
    default_face = 4;
  endtask

  task automatic test_random();
    int fs[4];
    int k, ep, er, rt;
    bit first;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      req = 4'($urandom_range(1, 15));
      first = 1'b1;
      while (req != 4'b0) begin
        faces.delete();
        for (int j = 0; j < 4; j++) begin
          fs[j] = $urandom_range(0, 7);
          faces.push_back(fs[j]);
        end
        ep = model_pick(ptr_m, req);
        k = 0;
        while (k < 4 && !(fs[k] >= 1 && fs[k] <= 6)) k++;
        if (k < 4) begin er = fs[k]; rt = k; end
        else begin er = 1; rt = 3; fault_m = 1'b1; end
        observe(80);
        checks++; if (o_ack !== 4'(1 << ep)) begin fails++; $display("FAIL rnd%0d_ack: got %b want %b", t, o_ack, 4'(1 << ep)); end
        checks++; if (o_res !== 3'(er)) begin fails++; $display("FAIL rnd%0d_result: got %0d want %0d", t, o_res, er); end
        checks++; if (o_fault !== fault_m) begin fails++; $display("FAIL rnd%0d_fault: got %b want %b", t, o_fault, fault_m); end
        checks++; if (o_ack_cyc != RC + 3 + 3 * rt + (first ? 0 : 1)) begin fails++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, o_ack_cyc, RC + 3 + 3 * rt + (first ? 0 : 1)); end
        req = (o_ack == 4'b0) ? 4'b0 : (req & ~o_ack);
        ptr_m = (ep + 1) % NP;
        first = 1'b0;
      end
    end
  endtask

`ifdef ROLL_SCORE_EN
  task automatic test_score();
    int total;
    pulse_reset();
    faces.delete();
    default_face = 6;
    total = 0;
    for (int i = 0; i < 44; i++) begin
      req = 4'b0001;
      observe(60);
      req = '0;
      total = (total + 6 > 255) ? 255 : total + 6;
      @(negedge clk);
      if (i == 20 || i >= 41) begin
        checks++; if (score[7:0] !== 8'(total)) begin fails++; $display("FAIL score_p0_%0d: got %0d want %0d", i, score[7:0], total); end
        checks++; if (score[31:8] !== 24'b0) begin fails++; $display("FAIL score_others_%0d: got %h want 0", i, score[31:8]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_withdraw();
    test_illegal();
    test_random();
`ifdef ROLL_SCORE_EN
    test_score();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
